// File: rtl/multicycle_cpu.sv
// Multicycle FSM core: parametrised register file, internal data memory,
// valid/ready instruction intake, ALU/LOAD/STORE/NOP classes.
module multicycle_cpu #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 5,
    parameter int unsigned REG_BITS   = 2,
    localparam int unsigned NUM_REGS    = 2**REG_BITS,
    localparam int unsigned INSTR_WIDTH = 14 + 3*REG_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           instr_valid,
    input  logic [INSTR_WIDTH-1:0]         instr,
    output logic                           instr_ready,
    output logic                           done,
    output logic                           illegal,
    output logic                           zero_flag,
    output logic                           carry_flag,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    input  logic [ADDR_BITS-1:0]           dbg_addr,
    output logic [DATA_WIDTH-1:0]          dbg_data
);

    localparam int unsigned MEM_DEPTH = 2**ADDR_BITS;
    localparam int unsigned DW1       = DATA_WIDTH + 1;
    localparam int unsigned SUM_W     = ((DATA_WIDTH > 8) ? DATA_WIDTH : 8) + 1;

    localparam logic [1:0] CLS_ALU   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_OR   = 4'd3;
    localparam logic [3:0] F_XOR  = 4'd4;
    localparam logic [3:0] F_SHL  = 4'd5;
    localparam logic [3:0] F_SHR  = 4'd6;
    localparam logic [3:0] F_ADDI = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t                  r_state;
    logic [INSTR_WIDTH-1:0]  r_ir;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_s;
    logic [DATA_WIDTH-1:0]   r_r;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   r_mem  [MEM_DEPTH];
    logic                    r_ready;
    logic                    r_done;
    logic                    r_illegal;
    logic                    r_zero;
    logic                    r_carry;

    logic [1:0]              w_cls;
    logic [REG_BITS-1:0]     w_x1;
    logic [REG_BITS-1:0]     w_x2;
    logic [REG_BITS-1:0]     w_x3;
    logic [7:0]              w_imm;
    logic [3:0]              w_func;
    logic [DATA_WIDTH-1:0]   w_imm_ext;
    logic [SUM_W-1:0]        w_ea_sum;
    logic [ADDR_BITS-1:0]    w_ea;
    logic [DATA_WIDTH-1:0]   w_alu_res;
    logic                    w_alu_carry;
    logic                    w_alu_legal;

    assign w_cls     = r_ir[INSTR_WIDTH-1 -: 2];
    assign w_x1      = r_ir[INSTR_WIDTH-3 -: REG_BITS];
    assign w_x2      = r_ir[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
    assign w_x3      = r_ir[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];
    assign w_imm     = r_ir[11:4];
    assign w_func    = r_ir[3:0];
    assign w_imm_ext = DATA_WIDTH'(w_imm);

    // Effective address wraps modulo the memory depth
    assign w_ea_sum = SUM_W'(r_a) + SUM_W'(w_imm);
    assign w_ea     = ADDR_BITS'(w_ea_sum);

    // ALU on latched operands; carry carries borrow / shifted-out bit
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_legal = 1'b1;
        case (w_func)
            F_ADD:  {w_alu_carry, w_alu_res} = DW1'(r_a) + DW1'(r_b);
            F_SUB:  begin
                w_alu_res   = r_a - r_b;
                w_alu_carry = (r_a < r_b);
            end
            F_AND:  w_alu_res = r_a & r_b;
            F_OR:   w_alu_res = r_a | r_b;
            F_XOR:  w_alu_res = r_a ^ r_b;
            F_SHL:  begin
                w_alu_res   = {r_a[DATA_WIDTH-2:0], 1'b0};
                w_alu_carry = r_a[DATA_WIDTH-1];
            end
            F_SHR:  begin
                w_alu_res   = {1'b0, r_a[DATA_WIDTH-1:1]};
                w_alu_carry = r_a[0];
            end
            F_ADDI: {w_alu_carry, w_alu_res} = DW1'(r_a) + DW1'(w_imm_ext);
            default: w_alu_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= '0;
            r_r       <= '0;
            r_addr    <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= DATA_WIDTH'(i);
            end
            for (int j = 0; j < MEM_DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                // Operands latched here make X1 aliasing X2/X3 harmless
                S_DECODE: begin
                    r_a     <= r_regs[w_x2];
                    r_b     <= r_regs[w_x3];
                    r_s     <= r_regs[w_x1];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_cls)
                        CLS_ALU: begin
                            r_r <= w_alu_res;
                            if (w_alu_legal) begin
                                r_zero  <= (w_alu_res == '0);
                                r_carry <= w_alu_carry;
                            end
                            r_state <= S_WB;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            r_addr  <= w_ea;
                            r_state <= S_MEM;
                        end
                        default: r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (w_cls == CLS_STORE) begin
                        r_mem[r_addr] <= r_s;
                    end else begin
                        r_r <= r_mem[r_addr];
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (((w_cls == CLS_ALU) && w_alu_legal) || (w_cls == CLS_LOAD)) begin
                        r_regs[w_x1] <= r_r;
                    end
                    r_done    <= 1'b1;
                    r_illegal <= (w_cls == CLS_ALU) && !w_alu_legal;
                    r_ready   <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign zero_flag   = r_zero;
    assign carry_flag  = r_carry;
    assign dbg_data    = r_mem[dbg_addr];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: integer reference model predicts each
// retirement; a monitor pops and compares on every done pulse.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [19:0] instr = '0;
    logic        instr_ready, done, illegal, zero_flag, carry_flag;
    logic [31:0] regs_flat;
    logic [4:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    logic        rst3 = 1'b1;
    logic        valid3 = 1'b0;
    logic [22:0] instr3 = '0;
    logic        ready3, done3, illegal3, zero3, carry3;
    logic [63:0] regs3;
    logic [4:0]  dbg_addr3 = '0;
    logic [7:0]  dbg_data3;

    multicycle_cpu dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .done(done), .illegal(illegal),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .regs_flat(regs_flat),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    multicycle_cpu #(.REG_BITS(3)) dut3 (
        .clk(clk), .rst(rst3), .instr_valid(valid3), .instr(instr3),
        .instr_ready(ready3), .done(done3), .illegal(illegal3),
        .zero_flag(zero3), .carry_flag(carry3), .regs_flat(regs3),
        .dbg_addr(dbg_addr3), .dbg_data(dbg_data3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] regs;
        bit          z;
        bit          c;
        bit          ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    int   m_regs [4];
    int   m_mem  [32];
    bit   m_z, m_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [19:0] mk(input int cls, input int x1, input int x2,
                                       input int x3, input int imm, input int fn);
        return {2'(cls), 2'(x1), 2'(x2), 2'(x3), 8'(imm), 4'(fn)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = i;
        for (int i = 0; i < 32; i++) m_mem[i] = 0;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    // Integer-arithmetic reference: apply one instruction, push the outcome
    task automatic model(input logic [19:0] ins, input int acc);
        int cls, x1, x2, x3, imm, fn, a, b, r, ea;
        exp_t e;
        cls = int'(ins[19:18]); x1 = int'(ins[17:16]); x2 = int'(ins[15:14]);
        x3  = int'(ins[13:12]); imm = int'(ins[11:4]); fn = int'(ins[3:0]);
        a = m_regs[x2]; b = m_regs[x3]; r = 0;
        ea = (a + imm) % 32;
        e.ill = 1'b0;
        e.lat = 3;
        case (cls)
            1: begin
                if (fn > 7) e.ill = 1'b1;
                else begin
                    case (fn)
                        0: begin r = a + b;   m_c = (r > 255); r = r % 256; end
                        1: begin m_c = (a < b); r = (a - b + 256) % 256; end
                        2: begin r = a & b; m_c = 1'b0; end
                        3: begin r = a | b; m_c = 1'b0; end
                        4: begin r = a ^ b; m_c = 1'b0; end
                        5: begin m_c = (a > 127); r = (a * 2) % 256; end
                        6: begin m_c = (a % 2 == 1); r = a / 2; end
                        default: begin r = a + imm; m_c = (r > 255); r = r % 256; end
                    endcase
                    m_z = (r == 0);
                    m_regs[x1] = r;
                end
            end
            2: begin e.lat = 4; m_regs[x1] = m_mem[ea]; end
            3: begin e.lat = 4; m_mem[ea] = m_regs[x1]; end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) e.regs[i*8 +: 8] = 8'(m_regs[i]);
        e.z = m_z;
        e.c = m_c;
        e.acc = acc;
        q.push_back(e);
    endtask

    // Drive one instruction at the first IDLE negedge; hold keeps valid high
    task automatic issue(input logic [19:0] ins, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 64'(instr_ready), 64'd1);
            return;
        end
        instr_valid = 1'b1;
        instr = ins;
        model(ins, cyc + 1);
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor: sample 1 time unit after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("regs", 64'(regs_flat), 64'(e.regs));
                    chk("zero_flag", 64'(zero_flag), 64'(e.z));
                    chk("carry_flag", 64'(carry_flag), 64'(e.c));
                    chk("illegal", 64'(illegal), 64'(e.ill));
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end else if (illegal) begin
                chk("illegal_without_done", 64'(illegal), 64'd0);
            end
            if (instr_ready !== (q.size() == 0))
                chk("instr_ready", 64'(instr_ready), 64'(q.size() == 0));
        end
    end

    task automatic reset_in_exec();
        exp_t dummy;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = mk(1, 0, 1, 3, 0, 0);
        dummy = '{regs: '0, z: 1'b0, c: 1'b0, ill: 1'b0, acc: 0, lat: 0};
        q.push_back(dummy);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_regs", 64'(regs_flat), 64'h03020100);
        chk("abort_zero", 64'(zero_flag), 64'd0);
        chk("abort_carry", 64'(carry_flag), 64'd0);
    endtask

    task automatic run_dut3();
        int cnt, ndone;
        logic [22:0] ins3;
        ins3 = {2'b01, 3'd7, 3'd5, 3'd6, 8'd0, 4'd0};
        @(negedge clk);
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        chk("r3_reset_regs", regs3, 64'h0706050403020100);
        chk("r3_ready", 64'(ready3), 64'd1);
        valid3 = 1'b1;
        instr3 = ins3;
        @(posedge clk);
        @(negedge clk);
        valid3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done3) ndone++;
        end
        chk("r3_abort_done", 64'(ndone), 64'd0);
        chk("r3_abort_regs", regs3, 64'h0706050403020100);
        valid3 = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            valid3 = 1'b0;
            cnt++;
        end while (!done3 && cnt < 20);
        chk("r3_latency", 64'(cnt), 64'd4);
        chk("r3_r7", 64'(regs3[63:56]), 64'd11);
        chk("r3_zero", 64'(zero3), 64'd0);
        chk("r3_carry", 64'(carry3), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_regs", 64'(regs_flat), 64'h03020100);
        chk("reset_flags", 64'({zero_flag, carry_flag, done, illegal}), 64'd0);
        chk("reset_ready", 64'(instr_ready), 64'd1);

        // ADD chain and SUB with borrow
        issue(mk(1, 0, 1, 3, 0, 0), 0);
        drain();
        chk("tp1_r0", 64'(regs_flat[7:0]), 64'd4);
        issue(mk(1, 1, 0, 3, 0, 0), 0);
        issue(mk(1, 3, 0, 2, 0, 1), 0);
        issue(mk(1, 0, 2, 1, 0, 1), 0);
        drain();
        chk("tp2_r0", 64'(regs_flat[7:0]), 64'hFB);
        chk("tp2_carry", 64'(carry_flag), 64'd1);

        // STORE / LOAD round trip
        issue(20'b11_01_10_00_00001111_0000, 0);
        drain();
        dbg_addr = 5'd17;
        #1;
        chk("tp3_dbg17", 64'(dbg_data), 64'd7);
        issue(20'b10_11_10_00_00001111_0000, 0);
        drain();
        chk("tp3_r3", 64'(regs_flat[31:24]), 64'd7);

        // Address wrap: r3 = 3, 3 + 30 lands at address 1
        issue(mk(1, 3, 2, 0, 1, 7), 0);
        issue(mk(3, 0, 3, 0, 30, 0), 0);
        issue(mk(2, 1, 3, 0, 30, 0), 0);
        drain();
        dbg_addr = 5'd1;
        #1;
        chk("tp4_dbg1", 64'(dbg_data), 64'hFB);
        chk("tp4_r1", 64'(regs_flat[15:8]), 64'hFB);

        // valid held high across instructions, then an illegal func
        issue(mk(1, 2, 1, 1, 0, 0), 1);
        issue(mk(1, 0, 0, 2, 0, 4), 1);
        issue(mk(1, 1, 2, 2, 0, 2), 0);
        issue(mk(1, 0, 1, 2, 0, 9), 0);
        drain();

        reset_in_exec();

        for (int k = 0; k < 200; k++) begin
            issue(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 9)),
                  (k != 199) && ($urandom_range(0, 1) == 1));
        end
        drain();
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk("mem_sweep", 64'(dbg_data), 64'(m_mem[a]));
        end

        run_dut3();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
